// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous memory between the instruction-fetch
//   port (read-only) and the data-memory port (read/write). The data port has
//   priority. After STARVE_MAX consecutive lost arbitrations, fetch wins the
//   next one. Setting STARVE_MAX to 0 turns this guard off.
//
// Parameters
//   AW         word-address width on all ports
//   RD_LAT     memory read latency (1..4) from the sampling edge to mem_rdata
//   STARVE_MAX fetch losses tolerated before fetch is forced through
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   if_req/if_addr           fetch request and address (held until if_ack)
//   if_ack/if_rdata          one-cycle fetch completion, registered data
//   dm_req/dm_we/dm_addr     data request, write flag and address
//   dm_wdata/dm_wmask        store data and byte enables
//   dm_ack/dm_rdata          one-cycle data completion, registered load data
//   mem_en/mem_we/mem_addr   registered memory strobe, write enable, address
//   mem_wdata/mem_wmask      registered store data and byte enables
//   mem_rdata                memory read data
//   busy                     high whenever not idle
//   owner                    0 = fetch, 1 = data (meaningful while busy)
module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic [3:0]    dm_wmask,
  output logic          dm_ack,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t        state;
  logic [1:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          dm_win;
  logic          if_win;

  always_comb begin
    dm_win = 1'b0;
    if_win = 1'b0;
    if (dm_req && (!if_req || (STARVE_MAX == 0) || (starve_cnt < SMAX)))
      dm_win = 1'b1;
    else if (if_req)
      if_win = 1'b1;
  end

  // busy follows the state register directly, so reset clears it without a clock.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      owner      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_win) begin
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wmask <= dm_wmask;
            owner     <= 1'b1;
            state     <= ACCESS;
            // Fetch lost a contested arbitration: count it, saturating.
            if (if_req && (starve_cnt < SMAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (if_win) begin
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            owner      <= 1'b0;
            state      <= ACCESS;
            starve_cnt <= '0;
          end else begin
            mem_en <= 1'b0;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          if (mem_we) begin
            state <= RESP;
            // The ack is registered, so it is raised on entry to RESP.
            if (owner) dm_ack <= 1'b1;
            else       if_ack <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            if (owner) dm_rdata <= mem_rdata;
            else       if_rdata <= mem_rdata;
            if (owner) dm_ack <= 1'b1;
            else       if_ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. It uses two instances:
//   instance 0 has RD_LAT=1 and STARVE_MAX=2, and instance 1 has RD_LAT=3 and
//   STARVE_MAX=0. Stimulus pushes the expected acks into a queue. A monitor
//   pops an entry on every ack and compares port, cycle and read data.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          if_req   [NI];
  logic [AW-1:0] if_addr  [NI];
  logic          if_ack   [NI];
  logic [31:0]   if_rdata [NI];
  logic          dm_req   [NI];
  logic          dm_we    [NI];
  logic [AW-1:0] dm_addr  [NI];
  logic [31:0]   dm_wdata [NI];
  logic [3:0]    dm_wmask [NI];
  logic          dm_ack   [NI];
  logic [31:0]   dm_rdata [NI];
  logic          mem_en   [NI];
  logic          mem_we   [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [31:0]   mem_wdata[NI];
  logic [3:0]    mem_wmask[NI];
  logic          busy     [NI];
  logic          owner    [NI];

  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    if (a == 8'h04) return 32'h00500093;
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RL = (g == 0) ? 1 : 3;
    localparam int unsigned SM = (g == 0) ? 2 : 0;
    logic [31:0] pipe [4];
    logic [31:0] mem_rdata_g;

    // Read data is only meaningful in the single cycle RL edges after sampling.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? memf(mem_addr[g]) : 32'hBADBAD00;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
    assign mem_rdata_g = pipe[RL-1];

    mem_port_arbiter #(.AW(AW), .RD_LAT(RL), .STARVE_MAX(SM)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ack    (if_ack[g]),
      .if_rdata  (if_rdata[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_wmask  (dm_wmask[g]),
      .dm_ack    (dm_ack[g]),
      .dm_rdata  (dm_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wmask (mem_wmask[g]),
      .mem_rdata (mem_rdata_g),
      .busy      (busy[g]),
      .owner     (owner[g])
    );
  end

  typedef struct {
    int          inst;
    bit          port;   // 0 = fetch, 1 = data
    bit          wr;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_if[NI];
  logic [31:0] last_dm[NI];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input bit port, input bit wr,
                      input logic [31:0] rd, input int ack_cyc);
    exp_t e;
    e.inst = i; e.port = port; e.wr = wr; e.rdata = rd; e.cyc = ack_cyc;
    sbq.push_back(e);
  endtask

  task automatic monitor_step(input int i);
    int          idx;
    exp_t        e;
    logic [31:0] rd_exp;
    if (if_ack[i] && dm_ack[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dual_ack inst%0d: actual=both acks high required=at most one (cyc %0d)", i, cyc);
    end
    if (!(if_ack[i] || dm_ack[i])) return;
    idx = -1;
    foreach (sbq[k]) if (idx < 0 && sbq[k].inst == i) idx = k;
    if (idx < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_ack inst%0d: actual=ack port %0d cyc %0d required=no ack",
               i, dm_ack[i], cyc);
      return;
    end
    e = sbq[idx];
    sbq.delete(idx);
    check($sformatf("ack_port_inst%0d", i), 32'(dm_ack[i]), 32'(e.port));
    check($sformatf("ack_cycle_inst%0d", i), 32'(cyc), 32'(e.cyc));
    if (e.port) begin
      rd_exp = e.wr ? last_dm[i] : e.rdata;
      check($sformatf("dm_rdata_inst%0d", i), dm_rdata[i], rd_exp);
      check($sformatf("if_rdata_hold_inst%0d", i), if_rdata[i], last_if[i]);
      last_dm[i] = rd_exp;
    end else begin
      check($sformatf("if_rdata_inst%0d", i), if_rdata[i], e.rdata);
      check($sformatf("dm_rdata_hold_inst%0d", i), dm_rdata[i], last_dm[i]);
      last_if[i] = e.rdata;
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) monitor_step(i);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a request and keep it high through n acks, then drop it.
  // Call this just after a rising edge.
  task automatic run_req(input int i, input bit port, input int n, input bit wr,
                         input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] wm);
    int budget;
    bit got;
    if (port) begin
      dm_req[i] = 1'b1; dm_we[i] = wr; dm_addr[i] = a; dm_wdata[i] = wd; dm_wmask[i] = wm;
    end else begin
      if_req[i] = 1'b1; if_addr[i] = a;
    end
    for (int t = 0; t < n; t++) begin
      budget = 40;
      got = 1'b0;
      while (!got && budget > 0) begin
        @(negedge clk);
        got = port ? dm_ack[i] : if_ack[i];
        budget--;
      end
      if (!got) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout inst%0d port%0d: actual=no ack in 40 cycles required=ack", i, port);
      end
      @(posedge clk);
      #1;
    end
    if (port) dm_req[i] = 1'b0;
    else      if_req[i] = 1'b0;
  endtask

  int c0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
      dm_addr[i] = '0; dm_wdata[i] = '0; dm_wmask[i] = '0;
      last_if[i] = '0; last_dm[i] = '0;
    end
    rst = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_mem_en%0d", i), 32'(mem_en[i]), 0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("rst_owner%0d", i), 32'(owner[i]), 0);
      check($sformatf("rst_acks%0d", i), 32'({if_ack[i], dm_ack[i]}), 0);
      check($sformatf("rst_if_rdata%0d", i), if_rdata[i], 0);
      check($sformatf("rst_dm_rdata%0d", i), dm_rdata[i], 0);
      check($sformatf("rst_mem_bus%0d", i), 32'({mem_we[i], mem_wmask[i], mem_addr[i]}), 0);
      check($sformatf("rst_mem_wdata%0d", i), mem_wdata[i], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(1);

    // Fetch read on instance 0 (RD_LAT=1).
    c0 = cyc;
    push(0, 0, 0, 32'h00500093, c0 + 3);
    fork
      run_req(0, 0, 1, 0, 8'h04, '0, '0);
      begin
        @(negedge clk); check("t1_mem_en_c0", 32'(mem_en[0]), 0);
        @(negedge clk); check("t1_mem_en_c1", 32'(mem_en[0]), 1);
        check("t1_mem_addr", 32'(mem_addr[0]), 32'h04);
        check("t1_mem_we", 32'({mem_we[0], mem_wmask[0]}), 0);
        check("t1_busy_c1", 32'(busy[0]), 1);
        @(negedge clk); check("t1_mem_en_c2", 32'(mem_en[0]), 0);
        @(negedge clk);
        @(negedge clk); check("t1_busy_c4", 32'(busy[0]), 0);
      end
    join
    step(1);

    // Simultaneous requests: data first, fetch at the next IDLE.
    c0 = cyc;
    push(0, 1, 0, memf(8'h10), c0 + 3);
    push(0, 0, 0, memf(8'h08), c0 + 7);
    fork
      run_req(0, 1, 1, 0, 8'h10, '0, '0);
      run_req(0, 0, 1, 0, 8'h08, '0, '0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t2_owner_c1", 32'(owner[0]), 1);
        check("t2_mem_addr_c1", 32'(mem_addr[0]), 32'h10);
      end
    join

    // Starvation guard with STARVE_MAX=2: DM, DM, IF, DM, DM, IF.
    c0 = cyc;
    push(0, 1, 0, memf(8'h30), c0 + 3);
    push(0, 1, 0, memf(8'h30), c0 + 7);
    push(0, 0, 0, memf(8'h31), c0 + 11);
    push(0, 1, 0, memf(8'h30), c0 + 15);
    push(0, 1, 0, memf(8'h30), c0 + 19);
    push(0, 0, 0, memf(8'h31), c0 + 23);
    fork
      run_req(0, 1, 4, 0, 8'h30, '0, '0);
      run_req(0, 0, 2, 0, 8'h31, '0, '0);
    join

    // Masked write; operands change after grant and must be ignored.
    c0 = cyc;
    push(0, 1, 1, '0, c0 + 2);
    fork
      run_req(0, 1, 1, 1, 8'h20, 32'hDEADBEEF, 4'b0011);
      begin
        @(negedge clk);
        @(posedge clk); #1;
        dm_addr[0] = 8'h21; dm_wdata[0] = 32'h0;
        @(negedge clk);
        check("t4_mem_en", 32'(mem_en[0]), 1);
        check("t4_mem_we", 32'(mem_we[0]), 1);
        check("t4_mem_wmask", 32'(mem_wmask[0]), 32'h3);
        check("t4_mem_addr", 32'(mem_addr[0]), 32'h20);
        check("t4_mem_wdata", mem_wdata[0], 32'hDEADBEEF);
      end
    join

    // RD_LAT=3 data read on instance 1.
    c0 = cyc;
    push(1, 1, 0, memf(8'h44), c0 + 5);
    fork
      run_req(1, 1, 1, 0, 8'h44, '0, '0);
      begin
        @(negedge clk); check("t5_mem_en_c0", 32'(mem_en[1]), 0);
        @(negedge clk); check("t5_mem_en_c1", 32'(mem_en[1]), 1);
        @(negedge clk); check("t5_mem_en_c2", 32'(mem_en[1]), 0);
      end
    join

    // STARVE_MAX=0: data always wins while it requests.
    c0 = cyc;
    push(1, 1, 0, memf(8'h50), c0 + 5);
    push(1, 1, 0, memf(8'h50), c0 + 11);
    push(1, 0, 0, memf(8'h51), c0 + 17);
    fork
      run_req(1, 1, 2, 0, 8'h50, '0, '0);
      run_req(1, 0, 1, 0, 8'h51, '0, '0);
    join

    // Write with an empty byte mask still completes.
    c0 = cyc;
    push(1, 1, 1, '0, c0 + 2);
    fork
      run_req(1, 1, 1, 1, 8'h52, 32'h12345678, 4'b0000);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t7_mem_we", 32'(mem_we[1]), 1);
        check("t7_mem_wmask", 32'(mem_wmask[1]), 0);
      end
    join

    // Asynchronous reset mid-transaction: instance 1 in WAIT, instance 0 in ACCESS.
    c0 = cyc;
    if_req[1] = 1'b1; if_addr[1] = 8'h60;
    step(2);
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 8'h61;
    step(1);
    #2;
    check("t8_pre_mem_en0", 32'(mem_en[0]), 1);
    check("t8_pre_busy1", 32'(busy[1]), 1);
    rst = 1'b0;
    #1;
    check("t8_mem_en0", 32'(mem_en[0]), 0);
    check("t8_busy0", 32'(busy[0]), 0);
    check("t8_busy1", 32'(busy[1]), 0);
    check("t8_acks", 32'({if_ack[0], dm_ack[0], if_ack[1], dm_ack[1]}), 0);
    check("t8_if_rdata0", if_rdata[0], 0);
    check("t8_dm_rdata1", dm_rdata[1], 0);
    for (int i = 0; i < NI; i++) begin
      last_if[i] = '0; last_dm[i] = '0;
    end
    if_req[1] = 1'b0; dm_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(8);
    check("t8_idle_busy1", 32'(busy[1]), 0);
    c0 = cyc;
    push(1, 0, 0, memf(8'h62), c0 + 5);
    run_req(1, 0, 1, 0, 8'h62, '0, '0);
    step(4);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_acks: actual=%0d outstanding required=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
